// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of an external LIFO stack datapath.
// Tracks occupancy, issues push/pop strobes and returns one registered response per accepted request.
module stack_arbiter #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic [1:0]       rsp_valid,
    output logic [1:0]       rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_rdata,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);

    localparam logic STATE_IDLE     = 1'b0;
    localparam logic STATE_POP_WAIT = 1'b1;
    localparam logic [3:0] DEPTH_C  = 4'(DEPTH);

    logic       state;
    logic       rp;
    logic       owner;
    logic       winner;
    logic       accept;
    logic       win_op;
    logic [1:0] win_oh;

    // With both requesters valid the pointer decides; otherwise the lone requester wins.
    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = rp;
        end else begin
            winner = req_valid[1];
        end
    end

    assign accept    = !rst && (state == STATE_IDLE) && (req_valid != 2'b00);
    assign win_oh    = winner ? 2'b10 : 2'b01;
    assign req_ready = accept ? win_oh : 2'b00;
    assign win_op    = winner ? req_op[1] : req_op[0];
    assign stk_wdata = winner ? req_data1 : req_data0;
    assign full      = (count == DEPTH_C);
    assign empty     = (count == 4'd0);
    assign stk_push  = accept && win_op && !full;
    assign stk_pop   = accept && !win_op && !empty;

    // A successful pop parks in POP_WAIT for one cycle so the stack read data can be captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STATE_IDLE;
            rp        <= 1'b0;
            owner     <= 1'b0;
            count     <= 4'd0;
            rsp_valid <= 2'b00;
            rsp_err   <= 2'b00;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_err   <= 2'b00;
            if (state == STATE_POP_WAIT) begin
                rsp_data  <= stk_rdata;
                rsp_valid <= owner ? 2'b10 : 2'b01;
                state     <= STATE_IDLE;
            end else if (accept) begin
                rp <= ~winner;
                if (win_op) begin
                    rsp_valid <= win_oh;
                    if (full) begin
                        rsp_err <= win_oh;
                    end else begin
                        count <= count + 4'd1;
                    end
                end else if (empty) begin
                    rsp_valid <= win_oh;
                    rsp_err   <= win_oh;
                    rsp_data  <= '0;
                end else begin
                    count <= count - 4'd1;
                    owner <= winner;
                    state <= STATE_POP_WAIT;
                end
            end
        end
    end

endmodule
